// File: rtl/hard_mem_1rw_bit_mask_tiled_wrapper_pkg.sv
// Shared types and macro pin defaults for the tiled
// 1RW bit-masked memory wrapper.
package hard_mem_tiled_pkg;

  typedef enum logic {
    e_init,
    e_ready
  } state_e;

  localparam logic [2:0] ema_def_lp  = 3'd3;
  localparam logic [1:0] emaw_def_lp = 2'd1;
  localparam logic [1:0] emas_def_lp = 2'd1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/hard_mem_1rw_bit_mask_tiled_wrapper_tile.sv
// One physical tile: pin mapping to the macro plus a
// behavioural stand-in for the hardened macro.
module hard_mem_tile_macro #(
  parameter int width_p = 32,
  parameter int els_p = 128,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     cen_i,
  input  logic                     gwen_i,
  input  logic [addr_width_lp-1:0] a_i,
  input  logic [width_p-1:0]       d_i,
  input  logic [width_p-1:0]       wen_i,
  input  logic [2:0]               ema_i,
  input  logic [1:0]               emaw_i,
  input  logic [1:0]               emas_i,
  input  logic                     ret1n_i,
  input  logic                     stov_i,
  output logic [width_p-1:0]       q_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] q_q;
  logic               active;
  logic               unused_pins;

  assign active = ~cen_i & ret1n_i;
  assign unused_pins = ^{ema_i, emaw_i, emas_i, stov_i};

  // Active-low per-bit write enable; Q only moves on reads.
  always_ff @(posedge clk_i) begin
    if (active & ~gwen_i) begin
      mem_q[a_i] <= (mem_q[a_i] & wen_i) | (d_i & ~wen_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (active & gwen_i) begin
      q_q <= mem_q[a_i];
    end
  end

  assign q_o = q_q;

endmodule

module hard_mem_tile
  import hard_mem_tiled_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 128,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic               cen_n;
  logic               gwen_n;
  logic [width_p-1:0] wen_n;

  assign cen_n  = ~en_i;
  assign gwen_n = ~w_i;
  assign wen_n  = ~w_mask_i;

  hard_mem_tile_macro #(
    .width_p(width_p),
    .els_p  (els_p)
  ) mem (
    .clk_i  (clk_i),
    .cen_i  (cen_n),
    .gwen_i (gwen_n),
    .a_i    (addr_i),
    .d_i    (data_i),
    .wen_i  (wen_n),
    .ema_i  (ema_def_lp),
    .emaw_i (emaw_def_lp),
    .emas_i (emas_def_lp),
    .ret1n_i(1'b1),
    .stov_i (1'b1),
    .q_o    (data_o)
  );

endmodule

// File: rtl/hard_mem_1rw_bit_mask_tiled_wrapper.sv
// Logical width_p x els_p bit-masked 1RW memory built from a
// rows x cols grid of tiles, with optional zeroing sweep.
module hard_mem_1rw_bit_mask_tiled_wrapper
  import hard_mem_tiled_pkg::*;
#(
  parameter int width_p = 96,
  parameter int els_p = 512,
  parameter int tile_width_p = 32,
  parameter int tile_els_p = 128,
  parameter bit init_zero_p = 1'b1,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o
);

  localparam int cols_lp = ceil_div(width_p, tile_width_p);
  localparam int rows_lp = els_p / tile_els_p;
  localparam int taw_lp  = $clog2(tile_els_p);
  localparam int pad_lp  = cols_lp * tile_width_p;
  localparam int rsw_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam int rsz_lp  = 2 ** rsw_lp;

  localparam logic [taw_lp-1:0] cnt_max_lp = taw_lp'(tile_els_p - 1);
  localparam logic [addr_width_lp:0] els_lim_lp = (addr_width_lp + 1)'(els_p);
  localparam state_e rst_state_lp = init_zero_p ? e_init : e_ready;

  if (els_p % tile_els_p != 0) begin : g_bad_els
    $error("els_p must be a multiple of tile_els_p");
  end
  if ((tile_els_p & (tile_els_p - 1)) != 0) begin : g_bad_tile
    $error("tile_els_p must be a power of two");
  end
  if (width_p < 1) begin : g_bad_width
    $error("width_p must be at least 1");
  end

  state_e              state_q, state_d;
  logic [taw_lp-1:0]   cnt_q, cnt_d;
  logic [rsw_lp-1:0]   rd_row_q, rd_row_d;
  logic                rd_seen_q, rd_seen_d;

  logic [rsw_lp-1:0]   row_idx;
  logic                in_range;
  logic [rows_lp-1:0]  row_en;
  logic                tile_w;
  logic [taw_lp-1:0]   tile_addr;
  logic [pad_lp-1:0]   tile_data;
  logic [pad_lp-1:0]   tile_mask;
  logic [pad_lp-1:0]   data_pad;
  logic [pad_lp-1:0]   mask_pad;
  logic [pad_lp-1:0]   q_rows [rsz_lp];
  logic [pad_lp-1:0]   q_sel;

  if (rows_lp > 1) begin : g_row
    assign row_idx = rsw_lp'(addr_i[addr_width_lp-1:taw_lp]);
  end else begin : g_row1
    assign row_idx = '0;
  end

  assign in_range = {1'b0, addr_i} < els_lim_lp;
  assign data_pad = pad_lp'(data_i);
  assign mask_pad = pad_lp'(w_mask_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_row_d  = rd_row_q;
    rd_seen_d = rd_seen_q;
    ready_o   = 1'b0;
    row_en    = '0;
    tile_w    = 1'b0;
    tile_addr = addr_i[taw_lp-1:0];
    tile_data = data_pad;
    tile_mask = mask_pad;
    unique case (state_q)
      e_init: begin
        row_en    = '1;
        tile_w    = 1'b1;
        tile_addr = cnt_q;
        tile_data = '0;
        tile_mask = '1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == cnt_max_lp) begin
          state_d = e_ready;
        end
      end
      e_ready: begin
        ready_o = 1'b1;
        if (v_i && in_range) begin
          row_en = rows_lp'(1) << row_idx;
          tile_w = w_i;
          if (!w_i) begin
            rd_row_d  = row_idx;
            rd_seen_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= rst_state_lp;
      cnt_q     <= '0;
      rd_row_q  <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_row_q  <= rd_row_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  for (genvar r = 0; r < rsz_lp; r++) begin : g_r
    if (r < rows_lp) begin : g_live
      for (genvar c = 0; c < cols_lp; c++) begin : g_c
        hard_mem_tile #(
          .width_p(tile_width_p),
          .els_p  (tile_els_p)
        ) u_tile (
          .clk_i   (clk_i),
          .en_i    (row_en[r]),
          .w_i     (tile_w),
          .addr_i  (tile_addr),
          .data_i  (tile_data[c*tile_width_p +: tile_width_p]),
          .w_mask_i(tile_mask[c*tile_width_p +: tile_width_p]),
          .data_o  (q_rows[r][c*tile_width_p +: tile_width_p])
        );
      end
    end else begin : g_dead
      assign q_rows[r] = '0;
    end
  end

  assign q_sel  = q_rows[rd_row_q];
  assign data_o = rd_seen_q ? q_sel[width_p-1:0] : '0;

  if (pad_lp > width_p) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^q_sel[pad_lp-1:width_p];
  end

endmodule

// File: tb/tb_hard_mem_1rw_bit_mask_tiled_wrapper.sv
// Directed bench for the tiled bit-masked memory wrapper
// at its default 96 x 512 geometry.
module tb_hard_mem_1rw_bit_mask_tiled_wrapper;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic        w_i;
  logic [8:0]  addr_i;
  logic [95:0] data_i;
  logic [95:0] w_mask_i;
  logic        ready_o;
  logic [95:0] data_o;

  int n_run;
  int n_fail;

  localparam logic [95:0] ones = {96{1'b1}};
  localparam logic [95:0] a5   = {12{8'hA5}};
  localparam logic [95:0] a5lo = {{11{8'hA5}}, 8'h00};
  localparam logic [95:0] pat  = 96'h0123_4567_89AB_CDEF_1234_5678;

  hard_mem_1rw_bit_mask_tiled_wrapper dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .w_i     (w_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .w_mask_i(w_mask_i),
    .ready_o (ready_o),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [95:0] got,
                     input logic [95:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic w, input logic [8:0] a,
                     input logic [95:0] d, input logic [95:0] m);
    v_i = 1'b1;
    w_i = w;
    addr_i = a;
    data_i = d;
    w_mask_i = m;
    @(posedge clk);
    #1;
    v_i = 1'b0;
    w_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    n_run = 0;
    n_fail = 0;
    reset_i = 1'b1;
    v_i = 1'b0;
    w_i = 1'b0;
    addr_i = '0;
    data_i = '0;
    w_mask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 96'(ready_o), 96'd0);
    chk("rst_data", data_o, 96'd0);

    // Write attempt during the sweep must be dropped.
    reset_i = 1'b0;
    v_i = 1'b1;
    w_i = 1'b1;
    addr_i = 9'd7;
    data_i = ones;
    w_mask_i = ones;
    wait_ready(n);
    v_i = 1'b0;
    w_i = 1'b0;
    chk("sweep_len", 96'(n), 96'd128);
    chk("init_data", data_o, 96'd0);

    acc(1'b1, 9'd5, ones, ones);
    acc(1'b0, 9'd5, '0, '0);
    chk("rd5", data_o, ones);
    repeat (10) @(posedge clk);
    #1;
    chk("hold5", data_o, ones);

    acc(1'b0, 9'd7, '0, '0);
    chk("rd7_init_drop", data_o, 96'd0);
    acc(1'b0, 9'h1FF, '0, '0);
    chk("rd1ff", data_o, 96'd0);

    acc(1'b1, 9'd300, a5, ones);
    acc(1'b1, 9'd300, '0, 96'hFF);
    acc(1'b0, 9'd300, '0, '0);
    chk("rd300_mask", data_o, a5lo);
    acc(1'b0, 9'd44, '0, '0);
    chk("rd44", data_o, 96'd0);

    acc(1'b0, 9'd300, '0, '0);
    acc(1'b1, 9'd10, pat, ones);
    chk("hold_wr", data_o, a5lo);
    acc(1'b0, 9'd10, '0, '0);
    chk("rd10", data_o, pat);

    acc(1'b1, 9'd10, ones, '0);
    acc(1'b0, 9'd10, '0, '0);
    chk("mask0", data_o, pat);

    // Reset in the middle of a sweep restarts it from zero.
    reset_i = 1'b1;
    #1;
    chk("arst_data", data_o, 96'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("mid_ready", 96'(ready_o), 96'd0);
    reset_i = 1'b1;
    #1;
    chk("midrst_ready", 96'(ready_o), 96'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("midrst_data", data_o, 96'd0);
    wait_ready(n);
    chk("sweep2_len", 96'(n), 96'd128);

    acc(1'b0, 9'd300, '0, '0);
    chk("rd300_zero", data_o, 96'd0);
    acc(1'b0, 9'd5, '0, '0);
    chk("rd5_zero", data_o, 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
